// File: rtl/btn_press_classifier.sv
// btn_press_classifier
// Turns the debounced button level into one single-cycle pulse per gesture:
// short press, long press (fires while still held) or double press.
// Time is measured in prescaler ticks (one tick every 2^CNT_W clocks). The
// prescaler free-runs, so every duration carries up to one tick of jitter.
module btn_press_classifier #(
    parameter int CNT_W      = 2,
    parameter int TW         = 4,
    parameter int LONG_TICKS = 8,
    parameter int GAP_TICKS  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic short_p,
    output logic long_p,
    output logic double_p,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        LONGHELD = 3'd2,
        GAP      = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam logic [TW-1:0] T_MAX     = '1;
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [TW-1:0]    t_q, t_d;
    logic             db_q, db_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             busy_q, busy_d;

    logic rise;
    logic fall;
    logic m_tick;

    // Edge detection, timebase, gesture FSM transitions and tick counting.
    always_comb begin
        rise     = db & ~db_q;
        fall     = ~db & db_q;
        m_tick   = (p_q == '0);

        db_d     = db;
        p_d      = p_q + 1'b1;
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                // A release on the final tick still counts as a short press.
                if (fall) begin
                    state_d = GAP;
                end else if (m_tick && (t_q == LONG_LAST)) begin
                    state_d = LONGHELD;
                    long_d  = 1'b1;
                end
            end
            LONGHELD: begin
                if (fall) state_d = IDLE;
            end
            GAP: begin
                // A second press on the timeout tick still counts as a double.
                if (rise) begin
                    state_d  = WAIT_REL;
                    double_d = 1'b1;
                end else if (m_tick && (t_q == GAP_LAST)) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            WAIT_REL: begin
                if (fall) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Tick counter restarts on every state change and saturates otherwise.
        if (state_d != state_q) begin
            t_d = '0;
        end else if (m_tick && (t_q != T_MAX)) begin
            t_d = t_q + 1'b1;
        end else begin
            t_d = t_q;
        end

        busy_d = (state_q != IDLE);
    end

    // State, timebase and registered outputs; db_q resets high so a button
    // held through reset is not seen as a press until released and re-pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            p_q      <= '0;
            t_q      <= '0;
            db_q     <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            t_q      <= t_d;
            db_q     <= db_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            busy_q   <= busy_d;
        end
    end

    assign short_p  = short_q;
    assign long_p   = long_q;
    assign double_p = double_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier (CNT_W=2, TW=4, LONG_TICKS=8, GAP_TICKS=4).
// Gestures come from a table; every expected pulse is queued with a latency
// window when its deciding input edge is driven, and popped when a pulse shows.
module tb_btn_press_classifier;

    localparam logic [1:0] K_SHORT  = 2'd1;
    localparam logic [1:0] K_LONG   = 2'd2;
    localparam logic [1:0] K_DOUBLE = 2'd3;

    typedef struct {
        logic [1:0] kind;
        int         ref_edge;
        int         lat_lo;
        int         lat_hi;
    } exp_t;

    typedef struct {
        int         hi1;
        int         lo;
        int         hi2;
        logic [1:0] kind;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic db;
    logic short_p;
    logic long_p;
    logic double_p;
    logic busy;

    exp_t exp_q[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    btn_press_classifier #(
        .CNT_W(2),
        .TW(4),
        .LONG_TICKS(8),
        .GAP_TICKS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .db(db),
        .short_p(short_p),
        .long_p(long_p),
        .double_p(double_p),
        .busy(busy)
    );

    // Clock and reset-relative edge counter (the prescaler ticks when cyc%4==0).
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Scoreboard: every pulse must match the head of the expected queue.
    int         mon_n;
    int         mon_lat;
    logic [1:0] mon_k;
    exp_t       mon_e;
    always @(negedge clk) begin
        mon_n = int'(short_p) + int'(long_p) + int'(double_p);
        if (mon_n > 0) begin
            checks++;
            if (mon_n > 1) begin
                errors++;
                $display("FAIL mutex: short=%0b long=%0b double=%0b, required at most one high",
                         short_p, long_p, double_p);
            end
            mon_k = short_p ? K_SHORT : (long_p ? K_LONG : K_DOUBLE);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind %0d at edge %0d, required no pulse",
                         mon_k, cyc - 1);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_lat = (cyc - 1) - mon_e.ref_edge;
                if ((mon_k != mon_e.kind) || (mon_lat < mon_e.lat_lo) || (mon_lat > mon_e.lat_hi)) begin
                    errors++;
                    $display("FAIL pulse: kind %0d latency %0d, required kind %0d latency %0d..%0d",
                             mon_k, mon_lat, mon_e.kind, mon_e.lat_lo, mon_e.lat_hi);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right after db changes: the next edge samples it.
    task automatic push(input logic [1:0] kind, input int lo, input int hi);
        exp_t e;
        e.kind     = kind;
        e.ref_edge = cyc;
        e.lat_lo   = lo;
        e.lat_hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic actual, input logic req);
        checks++;
        if (actual !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, actual, req);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int req);
        checks++;
        if (actual != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, req);
        end
    endtask

    task automatic wait_align();
        while ((cyc % 4) != 0) step(1);
    endtask

    task automatic settle(input string name);
        step(40);
        check_bit({name, "_busy"}, busy, 1'b0);
        check_int({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic run_gesture(input vec_t v);
        db = 1'b1;
        if (v.kind == K_LONG) push(K_LONG, 29, 33);
        step(v.hi1);
        db = 1'b0;
        if (v.kind == K_SHORT) push(K_SHORT, 13, 16);
        if (v.hi2 > 0) begin
            step(v.lo);
            db = 1'b1;
            push(K_DOUBLE, 0, 0);
            step(v.hi2);
            db = 1'b0;
        end
        settle("vec");
    endtask

    initial begin
        vecs[0]  = '{hi1: 12, lo: 0,  hi2: 0, kind: K_SHORT};
        vecs[1]  = '{hi1: 60, lo: 0,  hi2: 0, kind: K_LONG};
        vecs[2]  = '{hi1: 8,  lo: 6,  hi2: 8, kind: K_DOUBLE};
        vecs[3]  = '{hi1: 1,  lo: 0,  hi2: 0, kind: K_SHORT};
        vecs[4]  = '{hi1: 28, lo: 0,  hi2: 0, kind: K_SHORT};
        vecs[5]  = '{hi1: 33, lo: 0,  hi2: 0, kind: K_LONG};
        vecs[6]  = '{hi1: 8,  lo: 12, hi2: 4, kind: K_DOUBLE};
        vecs[7]  = '{hi1: int'($urandom_range(1, 28)),  lo: 0, hi2: 0, kind: K_SHORT};
        vecs[8]  = '{hi1: int'($urandom_range(1, 28)),  lo: 0, hi2: 0, kind: K_SHORT};
        vecs[9]  = '{hi1: int'($urandom_range(33, 70)), lo: 0, hi2: 0, kind: K_LONG};
        vecs[10] = '{hi1: int'($urandom_range(33, 70)), lo: 0, hi2: 0, kind: K_LONG};
        vecs[11] = '{hi1: int'($urandom_range(1, 28)), lo: int'($urandom_range(1, 12)),
                     hi2: int'($urandom_range(1, 20)), kind: K_DOUBLE};

        // Button held through reset and afterwards: nothing may happen.
        reset = 1'b1;
        db    = 1'b1;
        step(4);
        check_bit("rst_short", short_p, 1'b0);
        check_bit("rst_long", long_p, 1'b0);
        check_bit("rst_double", double_p, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        reset = 1'b0;
        step(100);
        check_bit("held_busy", busy, 1'b0);
        check_int("held_pending", exp_q.size(), 0);
        db = 1'b0;
        step(3);
        db = 1'b1;
        step(2);
        check_bit("first_press_busy", busy, 1'b1);
        step(8);
        db = 1'b0;
        push(K_SHORT, 13, 16);
        settle("first_press");

        // Table of gestures.
        for (int i = 0; i < 12; i++) run_gesture(vecs[i]);

        // Long press: busy clears two cycles after the release.
        db = 1'b1;
        push(K_LONG, 29, 33);
        step(40);
        check_bit("long_busy_held", busy, 1'b1);
        db = 1'b0;
        step(2);
        check_bit("long_busy_release", busy, 1'b0);
        settle("long_rel");

        // Release on the 8th PRESS1 tick: short press, not long.
        wait_align();
        db = 1'b1;
        step(32);
        db = 1'b0;
        push(K_SHORT, 13, 16);
        settle("tie_long");

        // Second press on the 4th GAP tick: double press, not short.
        db = 1'b1;
        step(8);
        wait_align();
        db = 1'b0;
        step(16);
        db = 1'b1;
        push(K_DOUBLE, 0, 0);
        step(8);
        db = 1'b0;
        settle("tie_gap");

        // Reset during GAP abandons the gesture.
        db = 1'b1;
        step(8);
        db = 1'b0;
        step(5);
        check_bit("gap_busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_bit("gap_reset_busy", busy, 1'b0);
        check_bit("gap_reset_short", short_p, 1'b0);
        step(50);
        check_bit("gap_reset_busy_after", busy, 1'b0);
        check_int("gap_reset_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
